// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared width, default tap count, FSM state type and truncated multiply
package filt_pkg;

  localparam int DATA_W     = 32;
  localparam int N_TAPS_DEF = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Signed product keeping only the DATA_W least significant bits.
  function automatic logic [DATA_W-1:0] mul_lo(input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b);
    return DATA_W'(a * b);
  endfunction

endpackage

// File: rtl/filt_tap_mul.sv
// rtl/filt_tap_mul.sv - combinational signed multiplier returning the low DATA_W product bits
module filt_tap_mul #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] p_o
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  assign a_s = a_i;
  assign b_s = b_i;

  // The low half of a two's complement product does not depend on the upper operand bits' meaning,
  // so a DATA_W-wide result is exactly the truncated signed product.
  assign p_o = a_s * b_s;

endmodule

// File: rtl/filt_mac_sched.sv
// rtl/filt_mac_sched.sv - FIR sequencer sharing one multiplier across all taps
module filt_mac_sched #(
  parameter int N_TAPS = filt_pkg::N_TAPS_DEF,
  parameter int DATA_W = filt_pkg::DATA_W,
  parameter int TAP_AW = $clog2(N_TAPS)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  input  logic              coef_we,
  input  logic [TAP_AW-1:0] coef_addr,
  input  logic [DATA_W-1:0] coef_wdata,
  output logic              coef_err,
  output logic              busy
);

  import filt_pkg::*;

  localparam logic [TAP_AW-1:0] LAST_TAP  = TAP_AW'(N_TAPS - 1);
  localparam logic [TAP_AW:0]   TAP_LIMIT = (TAP_AW + 1)'(N_TAPS);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q [N_TAPS];
  logic [DATA_W-1:0] x_d [N_TAPS];
  logic [DATA_W-1:0] c_q [N_TAPS];
  logic [DATA_W-1:0] c_d [N_TAPS];
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [TAP_AW-1:0] tap_q, tap_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              coef_err_q, coef_err_d;

  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] acc_sum;
  logic              s_fire;
  logic              coef_ok;

  // The single multiplier always sees the tap currently addressed by the walker.
  filt_tap_mul #(
    .DATA_W (DATA_W)
  ) u_tap_mul (
    .a_i (c_q[tap_q]),
    .b_i (x_q[tap_q]),
    .p_o (prod)
  );

  assign acc_sum  = acc_q + prod;
  assign s_tready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign s_fire   = s_tvalid && s_tready;
  // Coefficients may only change while no MAC walk is reading them.
  assign coef_ok  = (state_q == IDLE) && ({1'b0, coef_addr} < TAP_LIMIT);

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign coef_err = coef_err_q;

  // Next-state logic: FSM transitions, delay-line shift, coefficient writes and accumulation.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    c_d        = c_q;
    acc_d      = acc_q;
    tap_d      = tap_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    coef_err_d = coef_we && !coef_ok;

    if (coef_we && coef_ok) begin
      c_d[coef_addr] = coef_wdata;
    end

    case (state_q)
      IDLE: begin
        if (s_fire) begin
          x_d[0] = s_tdata;
          for (int k = 1; k < N_TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          tap_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + 1'b1;
        if (tap_q == LAST_TAP) begin
          m_tdata_d  = acc_sum;
          m_tvalid_d = 1'b1;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (m_tready) begin
          m_tvalid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any walk and clears both delay line and coefficient bank.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      tap_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      coef_err_q <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      tap_q      <= tap_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      coef_err_q <= coef_err_d;
      for (int k = 0; k < N_TAPS; k++) begin
        x_q[k] <= x_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

endmodule

// File: doc/filt_mac_sched.md
Name: filt_mac_sched

Overview:
Sequencer that time-shares a single 32x32 signed, combinational, low-32-bit multiplier across all taps of a direct-form FIR filter.
- Accepts one sample per stream handshake and shifts it into a tap delay line.
- Walks the taps one per cycle, accumulates product-sum, then presents y[n] on an output stream.
- Sits between the input AXI-Stream adapter and the output adapter of the filt datapath.
- Holds the coefficient bank, written through a simple config port.

Parameters:
N_TAPS, 11, number of filter taps (>=2)
DATA_W, 32, sample/coefficient/result width, two's complement
TAP_AW, $clog2(N_TAPS), tap index / coefficient address width

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
s_tdata  in  DATA_W  input sample x[n]
s_tvalid  in  1  input sample valid
s_tready  out  1  block can accept a sample
m_tdata  out  DATA_W  filter output y[n]
m_tvalid  out  1  output valid
m_tready  in  1  downstream accepts output
coef_we  in  1  coefficient write strobe
coef_addr  in  TAP_AW  coefficient index k
coef_wdata  in  DATA_W  coefficient c[k]
coef_err  out  1  one-cycle pulse: write rejected
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release) forces the following:
  - state=IDLE.
  - delay line x[0..N_TAPS-1]=0; coefficients c[0..N_TAPS-1]=0.
  - acc=0, tap=0.
  - m_tdata=0, m_tvalid=0, coef_err=0, busy=0.
  - s_tready=1 in the first cycle after release.
- s_tready = (state==IDLE), combinational from the state register only; no dependence on s_tvalid.
- States:
  - IDLE: on s_tvalid&&s_tready, set x[0]<=s_tdata, x[k]<=x[k-1] for k>=1, acc<=0, tap<=0, then go to MAC. Otherwise stay.
  - MAC: each cycle acc <= acc + low32(c[tap]*x[tap]) and tap<=tap+1. When tap==N_TAPS-1, register m_tdata <= final sum, set m_tvalid<=1, go to OUT.
  - OUT: hold m_tdata/m_tvalid stable while !m_tready. On m_tready, set m_tvalid<=0 and go to IDLE.
- Arithmetic:
  - Product is the signed 32x32 product truncated to DATA_W LSBs.
  - Accumulator is DATA_W bits and wraps mod 2^DATA_W; no saturation.
  - Operands are read from registers in the same cycle (multiplier is combinational, zero latency).
- Latency and throughput:
  - Sample accepted at edge E0; m_tvalid high after edge E0+N_TAPS.
  - Throughput is 1 sample per N_TAPS+2 cycles with m_tready tied high (N_TAPS MAC cycles + OUT + IDLE).
- Coefficient port:
  - Write is accepted only when state==IDLE and coef_addr<N_TAPS; takes effect at the next edge.
  - Otherwise the write is dropped and coef_err pulses high for one cycle.
  - Write and sample acceptance in the same IDLE cycle are both honoured. The MAC that follows uses the new coefficient.
- Reset mid-MAC or mid-OUT aborts the operation. No output is produced, and the delay line and coefficients are cleared.
- m_tready while m_tvalid=0 is ignored. s_tvalid outside IDLE is ignored and the source must hold it.

Decomposition:
- Package filt_pkg holds: DATA_W, the default N_TAPS, a state enum {IDLE, MAC, OUT}, and a function mul_lo(a,b) returning the truncated signed product (reference model for the bench).
- One sub-module: filt_tap_mul, a combinational signed DATA_W x DATA_W -> DATA_W multiplier instanced once.
- The controller contains the FSM, delay line, coefficient bank and accumulator.

Test Plan:
1. Impulse response: load c[k]=k+1 (k=0..10); send 1 followed by 11 zeros -> outputs 1,2,...,11,0.
2. Signed/wrap: c[0]=0x7FFFFFFF, other taps 0, x=2 -> y=0xFFFFFFFE. Then c[0]=-3, x=5 -> y=0xFFFFFFF1.
3. Backpressure: m_tready low for 7 cycles after m_tvalid -> m_tdata stable, s_tready=0 throughout. Completes on m_tready=1, s_tready returns 1 the next cycle.
4. Throughput: m_tready=1, s_tvalid=1 continuously -> one accept every 13 cycles, first m_tvalid 11 cycles after first accept.
5. Config rejection: coef_we during MAC, and coef_we with addr=11 in IDLE -> coef_err pulse each, coefficients unchanged (verify by impulse).
6. Reset mid-MAC: assert ap_rst_n=0 at tap 5 -> m_tvalid stays 0; after release, busy=0, s_tready=1, impulse test gives all-zero outputs.
